// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states,
// divider iteration count and a two's-complement magnitude helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DIV_ITER = 32;
  localparam int ITER_W   = $clog2(DIV_ITER);

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes. The quotient/remainder
// outputs show the result of the step taken on the coming edge; done marks the last step.
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic              run_q, run_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] step_rem;
  logic [31:0] step_quo;

  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    // Remainder stays below the divisor, so bit 32 of diff is a clean borrow flag.
    fits      = ~diff[32];
    step_rem  = fits ? diff[31:0] : rem_shift[31:0];
    step_quo  = {quo_q[30:0], fits};
  end

  assign quotient  = step_quo;
  assign remainder = step_rem;
  assign done      = run_q && (cnt_q == ITER_W'(DIV_ITER - 1));

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (run_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      if (done) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ITER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit feeding the HI/LO register: fixed-latency multiplier,
// iterative divider with sign fixup, and the IDLE/MUL/DIV/DONE controller.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [63:0] hilo_output,
  output logic        hilo_wen,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic        uns_q, uns_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] hilo_q, hilo_d;

  logic        accept;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] dc_quo, dc_rem;
  logic        dc_done;
  logic [31:0] q_fix, r_fix;
  logic [63:0] div_result;

  assign accept = (state_q == IDLE) && start && !cancel;

  div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && op[1]),
    .abort     (cancel),
    .dividend  (magnitude(src_a, ~op[0])),
    .divisor   (magnitude(src_b, ~op[0])),
    .quotient  (dc_quo),
    .remainder (dc_rem),
    .done      (dc_done)
  );

  // Sign- or zero-extend to 64 bits; the truncated product is right for both.
  always_comb begin
    ext_a   = {{32{a_q[31] & ~uns_q}}, a_q};
    ext_b   = {{32{b_q[31] & ~uns_q}}, b_q};
    product = ext_a * ext_b;
  end

  always_comb begin
    q_fix = (!uns_q && (a_q[31] ^ b_q[31])) ? (~dc_quo + 32'd1) : dc_quo;
    r_fix = (!uns_q && a_q[31]) ? (~dc_rem + 32'd1) : dc_rem;
    if (b_q == 32'd0) begin
      div_result = {a_q, 32'hFFFF_FFFF};
    end else begin
      div_result = {r_fix, q_fix};
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    uns_d   = uns_q;
    a_d     = a_q;
    b_d     = b_q;
    hilo_d  = hilo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          uns_d   = op[0];
          a_d     = src_a;
          b_d     = src_b;
          mcnt_d  = 3'd0;
          state_d = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (mcnt_q == 3'(MUL_LAT - 1)) begin
          hilo_d  = product;
          state_d = DONE;
        end else begin
          mcnt_d = mcnt_q + 3'd1;
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (dc_done) begin
          hilo_d  = div_result;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcnt_q  <= 3'd0;
      uns_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      uns_q   <= uns_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hilo_q  <= hilo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign hilo_wen    = (state_q == DONE) && !cancel;
  assign hilo_output = hilo_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter MUL_LAT, default 2, multiply latency in cycles; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a  input  32  multiplicand or dividend.
REQ-007 src_b  input  32  multiplier or divisor.
REQ-008 cancel  input  1  pipeline flush; aborts the operation in flight.
REQ-009 busy  output  1  high while an operation occupies the unit.
REQ-010 hilo_output  output  64  result {HI[63:32], LO[31:0]}; feeds the HI/LO register's hilo_input.
REQ-011 hilo_wen  output  1  one-cycle write strobe to the HI/LO register.

Function
REQ-012 State machine SHALL have states IDLE, MUL, DIV and DONE; busy = (state != IDLE).
REQ-013 In IDLE, start=1 and cancel=0 at an edge SHALL latch op/src_a/src_b, then go to MUL (op[1]=0) or DIV (op[1]=1); start while busy SHALL be ignored.
REQ-014 MUL SHALL produce the 64-bit product (signed for MULT, unsigned for MULTU) and enter DONE MUL_LAT edges after acceptance.
REQ-015 DIV SHALL run a radix-2 restoring division on operand magnitudes for exactly 32 iterations, then enter DONE 32 edges after acceptance.
REQ-016 Signed DIV: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-017 Division result: LO = quotient, HI = remainder.
REQ-018 Divisor zero (DIV or DIVU): full latency; HI = src_a, LO = 32'hFFFFFFFF.
REQ-019 DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
REQ-020 hilo_output SHALL be registered on the edge entering DONE and held until the next result or reset.
REQ-021 hilo_wen = (state==DONE) & ~cancel: high for exactly one cycle, stable across the negative clock edge.
REQ-022 DONE SHALL return to IDLE on the next edge; earliest next accept is the edge after DONE.
REQ-023 cancel=1 in MUL or DIV SHALL return to IDLE at the next edge with no hilo_wen and hilo_output unchanged.
REQ-024 cancel=1 together with start in IDLE SHALL prevent acceptance.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, busy=0, hilo_wen=0, hilo_output=0, iteration counter 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no write strobe.
REQ-027 After reset deassertion, the first rising edge SHALL be able to accept start.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encodings, the state enumeration and DIV_ITER=32.
REQ-029 Iterative divider datapath SHALL be a sub-module div_core: magnitude in, quotient/remainder out, done flag.
REQ-030 Sign pre-processing and post-fixup, multiplier pipeline and FSM SHALL remain in muldiv_unit.

Verification
REQ-031 MULT src_a=32'hFFFFFFFD, src_b=5 -> hilo_output=64'hFFFFFFFF_FFFFFFF1; hilo_wen one cycle, MUL_LAT edges after accept.
REQ-032 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hilo_output=64'hFFFFFFFE_00000001.
REQ-033 DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; hilo_wen 32 edges after accept; busy high for 33 cycles.
REQ-034 DIVU 100 / 0 -> HI=32'h00000064, LO=32'hFFFFFFFF after 32 edges.
REQ-035 DIV cancelled at iteration 10 -> no hilo_wen, busy=0 next cycle; then MULTU 2 x 3 -> hilo_output=64'h6.
REQ-036 reset=0 asserted mid-DIV (between edges) -> busy, hilo_wen and hilo_output read 0 immediately; no later strobe.
